present_round_ctrl: RTL and testbench

Sequencing controller for the round-based, area-optimized PRESENT-80 encryption core. It drives the select of the 64-bit 2:1 state mux: plaintext load vs. round feedback. It also drives the key-register select and enables and supplies the 5-bit round counter to the key schedule. It wraps one encryption in a valid/ready handshake on input and output. The controller holds no cipher data; the cipher datapath stays combinational around the state and key registers.

---
 rtl/present_round_ctrl.sv | 102 ++++++++++
 tb/tb_present_round_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_round_ctrl.sv
// Sequencing controller for a round-based PRESENT-80 core: steers the state and
// key muxes/enables and supplies the round counter, with valid/ready on both ends.
module present_round_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             mux_sel,
  output logic             key_sel,
  output logic             state_en,
  output logic             key_en,
  output logic [CNT_W-1:0] round_cnt,
  output logic             last_round,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mux_sel    = 1'b0;
    key_sel    = 1'b0;
    state_en   = 1'b0;
    key_en     = 1'b0;
    last_round = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        // The load cycle is the only place an input reaches an output directly.
        if (in_valid) begin
          state_en  = 1'b1;
          key_en    = 1'b1;
          cnt_nxt   = ONE_CNT;
          state_nxt = ROUND;
        end
      end

      ROUND: begin
        mux_sel  = 1'b1;
        key_sel  = 1'b1;
        state_en = 1'b1;
        key_en   = 1'b1;
        busy     = 1'b1;
        if (cnt == LAST_CNT) begin
          last_round = 1'b1;
          state_nxt  = OUT;
        end else begin
          cnt_nxt = cnt + ONE_CNT;
        end
      end

      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign round_cnt = cnt;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: cycle-timed expectations derived from
// block acceptance time, plus a behavioural PRESENT-80 datapath for known-answer vectors.
module tb_present_round_ctrl;

  localparam int NR = 31;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic       in_ready, out_valid, mux_sel, key_sel, state_en, key_en, last_round, busy;
  logic [4:0] round_cnt;

  logic       in_valid3, out_ready3;
  logic       in_ready3, out_valid3, mux_sel3, key_sel3, state_en3, key_en3, last_round3, busy3;
  logic [4:0] round_cnt3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  present_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .mux_sel(mux_sel), .key_sel(key_sel),
    .state_en(state_en), .key_en(key_en), .round_cnt(round_cnt),
    .last_round(last_round), .busy(busy)
  );

  present_round_ctrl #(.NUM_ROUNDS(3), .CNT_W(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_ready(out_ready3), .mux_sel(mux_sel3), .key_sel(key_sel3),
    .state_en(state_en3), .key_en(key_en3), .round_cnt(round_cnt3),
    .last_round(last_round3), .busy(busy3)
  );

  // Observation vector: {in_ready, out_valid, busy, last_round, mux_sel, key_sel,
  // state_en, key_en, round_cnt}
  logic [12:0] obs;
  assign obs = {in_ready, out_valid, busy, last_round, mux_sel, key_sel,
                state_en, key_en, round_cnt};

  localparam logic [12:0] FULL_MASK = 13'h1FFF;
  localparam logic [12:0] OUT_MASK  = 13'b1111_00_11_11111; // mux/key select are don't-care in OUT

  function automatic logic [12:0] idle_vec(input logic [4:0] c, input logic iv);
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, iv, iv, c};
  endfunction

  function automatic logic [12:0] round_vec(input int k);
    return {1'b0, 1'b0, 1'b1, (k == NR), 1'b1, 1'b1, 1'b1, 1'b1, 5'(k)};
  endfunction

  function automatic logic [12:0] out_vec();
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'(NR)};
  endfunction

  // ---------------- behavioural PRESENT-80 datapath ----------------
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] k);
    logic [63:0] t, p;
    t = s ^ k;
    for (int i = 0; i < 16; i++) t[4*i +: 4] = sbox4(t[4*i +: 4]);
    p = '0;
    for (int i = 0; i < 63; i++) p[(i * 16) % 63] = t[i];
    p[63] = t[63];
    return p;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = sbox4(t[79:76]);
    t[19:15] = t[19:15] ^ rc;
    return t;
  endfunction

  logic [63:0] pt, dp_state, last_ct;
  logic [79:0] key_in, dp_key;

  always @(posedge clk) begin
    if (state_en) dp_state <= mux_sel ? round_fn(dp_state, dp_key[79:16]) : pt;
    if (key_en)   dp_key   <= key_sel ? key_upd(dp_key, round_cnt) : key_in;
  end

  // ---------------- stimulus helpers ----------------
  int          cyc;
  logic [4:0]  idle_cnt; // round_cnt expected while idle: 0 after reset, NR after a block

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // Runs one block from an idle settle point: accept, NR rounds, `stall` cycles of
  // backpressure in OUT, then back to IDLE. `noisy` randomises in_valid while busy.
  task automatic run_block(input string tag, input int stall, input bit noisy);
    logic [12:0] e;
    cyc = 0;
    in_valid = 1'b1;
    out_ready = 1'($urandom);
    #1;
    e = idle_vec(idle_cnt, 1'b1);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s accept cyc=%0d got=%h exp=%h", tag, cyc, obs, e);
    end
    for (int k = 1; k <= NR; k++) begin
      tick();
      in_valid = noisy ? 1'($urandom) : 1'b0;
      out_ready = 1'($urandom);
      #1;
      e = round_vec(k);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s round cyc=%0d got=%h exp=%h", tag, cyc, obs, e);
      end
    end
    for (int s = 0; s <= stall; s++) begin
      tick();
      in_valid = noisy ? 1'($urandom) : 1'b0;
      out_ready = (s == stall);
      #1;
      if (s == 0) last_ct = dp_state ^ dp_key[79:16];
      e = out_vec();
      n_tests++;
      if ((obs & OUT_MASK) !== e) begin
        n_fail++;
        $display("FAIL %s out cyc=%0d got=%h exp=%h", tag, cyc, obs, e);
      end
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    idle_cnt = 5'(NR);
    e = idle_vec(idle_cnt, 1'b0);
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s back_to_idle cyc=%0d got=%h exp=%h", tag, cyc, obs, e);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int n;
    // Start a block, then pull reset part way through the rounds.
    in_valid = 1'b1;
    tick();
    in_valid = 1'($urandom);
    out_ready = 1'($urandom);
    n = $urandom_range(2, 20);
    repeat (n) begin
      tick();
      in_valid = 1'($urandom);
      out_ready = 1'($urandom);
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_tests++;
      if (obs !== idle_vec(5'd0, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs, idle_vec(5'd0, 1'b0));
      end
    end
    rst_n = 1'b1;
    tick();
    #1;
    n_tests++;
    if (obs !== idle_vec(5'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", obs, idle_vec(5'd0, 1'b0));
    end
    idle_cnt = 5'd0;
  endtask

  task automatic test_single_block();
    run_block("single_block", 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_block("backpressure", 10, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [12:0] e;
    cyc = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int blk = 0; blk < 2; blk++) begin
      #1;
      e = idle_vec(blk == 0 ? idle_cnt : 5'(NR), 1'b1);
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL b2b_accept blk=%0d cyc=%0d got=%h exp=%h", blk, cyc, obs, e);
      end
      for (int k = 1; k <= NR; k++) begin
        tick();
        #1;
        n_tests++;
        if (obs !== round_vec(k)) begin
          n_fail++;
          $display("FAIL b2b_round cyc=%0d got=%h exp=%h", cyc, obs, round_vec(k));
        end
      end
      tick();
      #1;
      n_tests++;
      if ((obs & OUT_MASK) !== out_vec()) begin
        n_fail++;
        $display("FAIL b2b_out cyc=%0d got=%h exp=%h", cyc, obs, out_vec());
      end
      tick();
    end
    n_tests++;
    if (cyc != 2 * (NR + 2)) begin
      n_fail++;
      $display("FAIL b2b_period got=%0d exp=%0d", cyc, 2 * (NR + 2));
    end
    in_valid = 1'b0;
    #1;
    idle_cnt = 5'(NR);
    n_tests++;
    if (obs !== idle_vec(idle_cnt, 1'b0)) begin
      n_fail++;
      $display("FAIL b2b_idle got=%h exp=%h", obs, idle_vec(idle_cnt, 1'b0));
    end
  endtask

  task automatic test_reset_mid_op();
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      in_valid = 1'b0;
    end
    #1;
    n_tests++;
    if (obs !== round_vec(15)) begin
      n_fail++;
      $display("FAIL midrst_pre got=%h exp=%h", obs, round_vec(15));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (obs !== idle_vec(5'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL midrst_idle got=%h exp=%h", obs, idle_vec(5'd0, 1'b0));
    end
    // out_valid must stay low for the aborted block
    for (int i = 0; i < 20; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL midrst_quiet i=%0d got_ov=%b got_ir=%b exp_ov=0 exp_ir=1", i, out_valid, in_ready);
      end
    end
    idle_cnt = 5'd0;
    run_block("midrst_next", 0, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    for (int b = 0; b < 6; b++) begin
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        tick();
        in_valid = 1'b0;
        out_ready = 1'($urandom);
        #1;
        n_tests++;
        if (obs !== idle_vec(idle_cnt, 1'b0)) begin
          n_fail++;
          $display("FAIL random_gap b=%0d got=%h exp=%h", b, obs, idle_vec(idle_cnt, 1'b0));
        end
      end
      pt = {$urandom, $urandom};
      key_in = {16'($urandom), $urandom, $urandom};
      run_block("random", $urandom_range(0, 6), 1'b1);
    end
  endtask

  task automatic test_datapath();
    logic [63:0] pts [4];
    logic [79:0] keys [4];
    logic [63:0] cts [4];
    pts[0] = 64'h0;                 keys[0] = 80'h0;
    cts[0] = 64'h5579C1387B228445;
    pts[1] = 64'h0;                 keys[1] = {80{1'b1}};
    cts[1] = 64'hE72C46C0F5945049;
    pts[2] = {64{1'b1}};            keys[2] = 80'h0;
    cts[2] = 64'hA112FFC72F68417B;
    pts[3] = {64{1'b1}};            keys[3] = {80{1'b1}};
    cts[3] = 64'h3333DCD3213210D2;
    for (int v = 0; v < 4; v++) begin
      pt = pts[v];
      key_in = keys[v];
      run_block("datapath", 0, 1'b0);
      n_tests++;
      if (last_ct !== cts[v]) begin
        n_fail++;
        $display("FAIL datapath_ct v=%0d got=%h exp=%h", v, last_ct, cts[v]);
      end
    end
  endtask

  task automatic test_short();
    in_valid3 = 1'b1;
    out_ready3 = 1'b1;
    #1;
    n_tests++;
    if (in_ready3 !== 1'b1 || state_en3 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_accept got_ir=%b got_se=%b exp=1", in_ready3, state_en3);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      in_valid3 = 1'b0;
      #1;
      n_tests++;
      if (round_cnt3 !== 5'(k) || out_valid3 !== 1'b0 || last_round3 !== (k == 3)) begin
        n_fail++;
        $display("FAIL short_round k=%0d got_cnt=%0d got_ov=%b got_lr=%b", k, round_cnt3, out_valid3, last_round3);
      end
    end
    tick();
    #1;
    n_tests++;
    if (out_valid3 !== 1'b1 || in_ready3 !== 1'b0) begin
      n_fail++;
      $display("FAIL short_out got_ov=%b got_ir=%b exp_ov=1 exp_ir=0", out_valid3, in_ready3);
    end
    tick();
    #1;
    n_tests++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL short_idle got_ov=%b got_ir=%b exp_ov=0 exp_ir=1", out_valid3, in_ready3);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_valid3 = 1'b0;
    out_ready3 = 1'b0;
    pt = '0;
    key_in = '0;
    cyc = 0;
    idle_cnt = 5'd0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    test_datapath();
    test_short();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
